i2c_master_arbiter: RTL
=======================

Name: i2c_master_arbiter

Overview:
- Shares a single I2C_Master engine among NUM_REQ requesters using round-robin arbitration.
- Latches the winning requester's command (device address, R/W, write byte) and drives the master's start/command inputs.
- Waits for the master to finish, then returns the read byte and ACK status to the requester with a one-cycle done pulse.
- Sits between on-chip clients (sensor pollers, config loaders) and I2C_Master.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDX_W, 2, width of the grant index; must satisfy 2**IDX_W >= NUM_REQ.
- TIMEOUT_CYC, 4096, watchdog limit in clk cycles (used only with I2C_ARB_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  reset; synchronous, active-high.
- req  input  NUM_REQ  per-requester request level.
- req_rw  input  NUM_REQ  per-requester R/W select; 1 = read.
- req_addr  input  7*NUM_REQ  packed 7-bit device addresses; requester i uses bits [7i+6:7i].
- req_wdata  input  8*NUM_REQ  packed write bytes; requester i uses bits [8i+7:8i].
- grant  output  NUM_REQ  one-hot owner of the master; 0 when idle.
- grant_idx  output  IDX_W  binary index of the current owner.
- req_done  output  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  output  8  read byte; valid while req_done is high.
- nack  output  1  1 = slave did not acknowledge; valid while req_done is high.
- timeout  output  1  watchdog fired; valid while req_done is high (0 without the macro).
- busy  output  1  high in any state other than IDLE.
- m_start  output  1  to master s_bit.
- m_rw  output  1  to master RW_SEL.
- m_addr  output  7  to master Device_Addr.
- m_wdata  output  8  to master Data_in.
- m_done  input  1  master transaction-complete pulse.
- m_nack  input  1  master NACK flag; sampled with m_done.
- m_rdata  input  8  master Data_out; sampled with m_done.

Behaviour:
- Reset: when rst is high at a clk edge, the following apply on the next edge:
  - state = IDLE; rr_ptr = 0.
  - All outputs are 0: grant, grant_idx, req_done, rdata, nack, timeout, busy, m_start, m_rw, m_addr, m_wdata.
  - Reset overrides any state, including mid-transaction. No req_done is issued for an aborted transaction.
- Round-robin search:
  - The search starts at rr_ptr and wraps modulo NUM_REQ; the first set req bit wins.
  - rr_ptr = winner+1 (mod NUM_REQ), updated in DONE.
  - Result: a requester that was just served has the lowest priority next time.
- IDLE:
  - If any req bit is set at edge N, then at edge N+1: state = START, grant/grant_idx point to the winner, and m_rw/m_addr/m_wdata are loaded from the winner's fields.
  - The loaded command fields stay frozen until the next grant.
  - If no req bit is set, remain in IDLE.
- START:
  - m_start = 1; go to WAIT on the next edge.
- WAIT:
  - m_start stays 1 (level-held).
  - When m_done is seen at edge M: capture m_rdata into rdata and m_nack into nack, and go to DONE at M+1.
- DONE:
  - req_done[grant_idx] = 1 for exactly one cycle; m_start = 0; rr_ptr is updated.
  - On the next edge: state = IDLE, and grant, grant_idx and busy return to 0.
  - rdata and nack hold their values until the next capture.
- Latency and throughput:
  - From req sampled to m_start high: 1 cycle.
  - From m_done to req_done: 1 cycle.
  - At least 1 IDLE cycle separates back-to-back transactions.
- Boundary conditions:
  - Requester drops req mid-transaction: ignored. The transaction completes and req_done is still pulsed.
  - Owner still holds req when it receives req_done: it may be re-granted, but only after all other pending requesters are served.
  - m_done while not in WAIT: ignored.
  - m_done coincident with a new req in DONE/IDLE: no conflict, because arbitration happens only in IDLE.
  - Invalid rr_ptr (≥ NUM_REQ): treated as 0.

Optional Feature:
- Macro: I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT; it is cleared on entry to WAIT.
  - If it reaches TIMEOUT_CYC with no m_done, go to DONE with timeout = 1, nack = 1, rdata = 0, and m_start = 0.
  - The counter and timeout reset to 0.
- Undefined:
  - No counter is built; timeout is tied to 0; WAIT waits indefinitely.

Test Plan:
- Reset behaviour: rst held 2 cycles mid-WAIT -> all outputs 0 next edge, state IDLE, no req_done pulse.
- Single read: req=4'b0010, req_rw[1]=1, addr1=7'h50; master returns m_done with m_rdata=8'hA5, m_nack=0 -> grant=4'b0010 one edge after req, m_start high until DONE, req_done=4'b0010 for 1 cycle, rdata=8'hA5, nack=0.
- Round-robin fairness: req=4'b1111 held, each m_done after 20 cycles -> grant order 0,1,2,3,0; each req_done exactly once per round.
- Write with NACK: req[2] write, addr=7'h3C, wdata=8'h7E; m_nack=1 with m_done -> m_addr=7'h3C, m_wdata=8'h7E, m_rw=0 during WAIT; nack=1 on req_done[2].
- Request withdrawn: req[0] dropped 3 cycles into WAIT -> transaction completes, req_done[0] still pulses, next grant goes to the next pending requester.
- Watchdog: with I2C_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, m_done never asserted -> req_done 1 cycle after 16 WAIT cycles with timeout=1, nack=1, rdata=8'h00.

Source files
------------

// File: rtl/i2c_master_arbiter.sv
// Round-robin arbiter sharing one I2C master among NUM_REQ on-chip requesters.
// Optional watchdog on the master handshake is enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_master_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int IDX_W       = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [7*NUM_REQ-1:0] req_addr,
  input  logic [8*NUM_REQ-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   grant,
  output logic [IDX_W-1:0]     grant_idx,
  output logic [NUM_REQ-1:0]   req_done,
  output logic [7:0]           rdata,
  output logic                 nack,
  output logic                 timeout,
  output logic                 busy,
  output logic                 m_start,
  output logic                 m_rw,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_wdata,
  input  logic                 m_done,
  input  logic                 m_nack,
  input  logic [7:0]           m_rdata
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] next_ptr;

  logic             found;
  logic [IDX_W-1:0] win_idx;
  logic             win_rw;
  logic [6:0]       win_addr;
  logic [7:0]       win_wdata;
  int               base;
  int               cand;

  // Scan requesters starting at rr_ptr so the last one served ranks lowest.
  always_comb begin
    found     = 1'b0;
    win_idx   = '0;
    win_rw    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    cand      = 0;
    base      = (int'(rr_ptr) >= NUM_REQ) ? 0 : int'(rr_ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (base + k) % NUM_REQ;
      if (!found && req[cand]) begin
        found     = 1'b1;
        win_idx   = IDX_W'(cand);
        win_rw    = req_rw[cand];
        win_addr  = req_addr[7*cand +: 7];
        win_wdata = req_wdata[8*cand +: 8];
      end
    end
  end

  assign next_ptr = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] wd_cnt;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant     <= '0;
      grant_idx <= '0;
      req_done  <= '0;
      rdata     <= '0;
      nack      <= 1'b0;
      busy      <= 1'b0;
      m_start   <= 1'b0;
      m_rw      <= 1'b0;
      m_addr    <= '0;
      m_wdata   <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      timeout   <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (found) begin
            state     <= START;
            grant     <= NUM_REQ'(1) << win_idx;
            grant_idx <= win_idx;
            m_rw      <= win_rw;
            m_addr    <= win_addr;
            m_wdata   <= win_wdata;
            busy      <= 1'b1;
            m_start   <= 1'b1;
          end
        end
        START: begin
          state <= WAIT;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        WAIT: begin
          if (m_done) begin
            rdata    <= m_rdata;
            nack     <= m_nack;
            req_done <= grant;
            m_start  <= 1'b0;
            state    <= DONE;
`ifdef I2C_ARB_TIMEOUT_EN
            timeout  <= 1'b0;
          end else if (wd_cnt == WD_LAST) begin
            // Master never answered: report as a NACK with no data.
            rdata    <= '0;
            nack     <= 1'b1;
            timeout  <= 1'b1;
            req_done <= grant;
            m_start  <= 1'b0;
            state    <= DONE;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
`endif
          end
        end
        DONE: begin
          req_done  <= '0;
          rr_ptr    <= next_ptr;
          grant     <= '0;
          grant_idx <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
